// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: opcodes, ALU operation codes,
// immediate-extension, next-PC and write-back select values, and the decoded
// control bundle passed from the decoder to the ID/EX register.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Each ALU operation has its own code; 0 is reserved for "no operation".
    localparam logic [4:0] ALU_NOP    = 5'd0;
    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_SUB    = 5'd2;
    localparam logic [4:0] ALU_SLL    = 5'd3;
    localparam logic [4:0] ALU_SLT    = 5'd4;
    localparam logic [4:0] ALU_SLTU   = 5'd5;
    localparam logic [4:0] ALU_XOR    = 5'd6;
    localparam logic [4:0] ALU_SRL    = 5'd7;
    localparam logic [4:0] ALU_SRA    = 5'd8;
    localparam logic [4:0] ALU_OR     = 5'd9;
    localparam logic [4:0] ALU_AND    = 5'd10;
    localparam logic [4:0] ALU_LUI    = 5'd11;
    localparam logic [4:0] ALU_AUIPC  = 5'd12;
    localparam logic [4:0] ALU_BEQ    = 5'd13;
    localparam logic [4:0] ALU_BNE    = 5'd14;
    localparam logic [4:0] ALU_BLT    = 5'd15;
    localparam logic [4:0] ALU_BGE    = 5'd16;
    localparam logic [4:0] ALU_BLTU   = 5'd17;
    localparam logic [4:0] ALU_BGEU   = 5'd18;
    localparam logic [4:0] ALU_MUL    = 5'd19;
    localparam logic [4:0] ALU_MULH   = 5'd20;
    localparam logic [4:0] ALU_MULHSU = 5'd21;
    localparam logic [4:0] ALU_MULHU  = 5'd22;
    localparam logic [4:0] ALU_DIV    = 5'd23;
    localparam logic [4:0] ALU_DIVU   = 5'd24;
    localparam logic [4:0] ALU_REM    = 5'd25;
    localparam logic [4:0] ALU_REMU   = 5'd26;

    localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_JTYPE       = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       illegal;
        logic [4:0] alu_op;
        logic [5:0] ext_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Combinational instruction decoder for the IF/ID instruction. Produces the
// control bundle, register indices and which source registers are really read
// (the latter feeds load-use detection only).
module pipe_ctrl_dec
    import pipe_ctrl_pkg::*;
#(
    parameter int ENABLE_MEXT = 0,
    parameter int RF_AW       = 5
) (
    input  logic [31:0]      inst,
    input  logic             inst_valid,
    output ctrl_t            ctrl,
    output logic             use_rs1,
    output logic             use_rs2,
    output logic [RF_AW-1:0] rd,
    output logic [RF_AW-1:0] rs1,
    output logic [RF_AW-1:0] rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[7 +: RF_AW];
    assign rs1    = inst[15 +: RF_AW];
    assign rs2    = inst[20 +: RF_AW];

    // Opcode/funct decode; invalid or unmatched instructions collapse to zero control.
    always_comb begin
        ctrl    = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_LUI;
                ctrl.ext_op    = EXT_UTYPE;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_AUIPC;
                ctrl.ext_op    = EXT_UTYPE;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_op    = EXT_JTYPE;
                ctrl.npc_op    = NPC_JAL;
                ctrl.wd_sel    = WD_PC;
            end
            OPC_JALR: begin
                legal          = (funct3 == 3'b000);
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_op    = EXT_ITYPE;
                ctrl.npc_op    = NPC_JALR;
                ctrl.wd_sel    = WD_PC;
                use_rs1        = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.ext_op = EXT_BTYPE;
                ctrl.npc_op = NPC_BRANCH;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_op = ALU_BEQ;
                    3'b001:  ctrl.alu_op = ALU_BNE;
                    3'b100:  ctrl.alu_op = ALU_BLT;
                    3'b101:  ctrl.alu_op = ALU_BGE;
                    3'b110:  ctrl.alu_op = ALU_BLTU;
                    3'b111:  ctrl.alu_op = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal          = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_op    = EXT_ITYPE;
                ctrl.wd_sel    = WD_MEM;
                ctrl.dm_type   = funct3;
                use_rs1        = 1'b1;
            end
            OPC_STORE: begin
                legal          = (funct3 inside {3'b000, 3'b001, 3'b010});
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_op    = EXT_STYPE;
                ctrl.dm_type   = funct3;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_ITYPE;
                use_rs1        = 1'b1;
                case (funct3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl.ext_op = EXT_ITYPE_SHAMT;
                        ctrl.alu_op = ALU_SLL;
                        legal       = (funct7 == F7_BASE);
                    end
                    default: begin
                        ctrl.ext_op = EXT_ITYPE_SHAMT;
                        if (funct7 == F7_BASE)     ctrl.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ctrl.alu_op = ALU_ADD;
                        3'b001:  ctrl.alu_op = ALU_SLL;
                        3'b010:  ctrl.alu_op = ALU_SLT;
                        3'b011:  ctrl.alu_op = ALU_SLTU;
                        3'b100:  ctrl.alu_op = ALU_XOR;
                        3'b101:  ctrl.alu_op = ALU_SRL;
                        3'b110:  ctrl.alu_op = ALU_OR;
                        default: ctrl.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  ctrl.alu_op = ALU_SUB;
                        3'b101:  ctrl.alu_op = ALU_SRA;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_MEXT && ENABLE_MEXT != 0) begin
                    case (funct3)
                        3'b000:  ctrl.alu_op = ALU_MUL;
                        3'b001:  ctrl.alu_op = ALU_MULH;
                        3'b010:  ctrl.alu_op = ALU_MULHSU;
                        3'b011:  ctrl.alu_op = ALU_MULHU;
                        3'b100:  ctrl.alu_op = ALU_DIV;
                        3'b101:  ctrl.alu_op = ALU_DIVU;
                        3'b110:  ctrl.alu_op = ALU_REM;
                        default: ctrl.alu_op = ALU_REMU;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        // An illegal instruction carries only its illegal flag so it cannot
        // write state, redirect, or take part in hazard detection.
        if (!inst_valid || !legal) begin
            ctrl    = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            ctrl.illegal = inst_valid;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: decode, hazard handling (load-use stall,
// taken-branch flush, external freeze), ID/EX, EX/MEM and MEM/WB control
// registers, and operand forwarding selects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ENABLE_MEXT = 0,
    parameter int RF_AW       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_id,
    input  logic             inst_valid,
    input  logic             br_taken_ex,
    input  logic             stall_ext,
    output logic             stall_if,
    output logic             flush_ifid,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic             ex_MemRead,
    output logic             ex_ALUSrc,
    output logic             ex_illegal,
    output logic [4:0]       ex_ALUOp,
    output logic [5:0]       ex_EXTOp,
    output logic [2:0]       ex_NPCOp,
    output logic [1:0]       ex_WDSel,
    output logic [2:0]       ex_DMType,
    output logic [RF_AW-1:0] ex_rd,
    output logic [RF_AW-1:0] ex_rs1,
    output logic [RF_AW-1:0] ex_rs2,
    output logic             mem_RegWrite,
    output logic [1:0]       mem_WDSel,
    output logic [RF_AW-1:0] mem_rd,
    output logic             wb_RegWrite,
    output logic [RF_AW-1:0] wb_rd,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB
);

    typedef struct packed {
        logic             valid;
        ctrl_t            ctrl;
        logic [RF_AW-1:0] rd;
        logic [RF_AW-1:0] rs1;
        logic [RF_AW-1:0] rs2;
    } idex_t;

    ctrl_t            id_ctrl;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [RF_AW-1:0] id_rd;
    logic [RF_AW-1:0] id_rs1;
    logic [RF_AW-1:0] id_rs2;
    logic             load_use;
    logic             bubble;
    idex_t            idex_d;
    idex_t            idex_q;

    pipe_ctrl_dec #(
        .ENABLE_MEXT (ENABLE_MEXT),
        .RF_AW       (RF_AW)
    ) u_dec (
        .inst       (inst_id),
        .inst_valid (inst_valid),
        .ctrl       (id_ctrl),
        .use_rs1    (id_use_rs1),
        .use_rs2    (id_use_rs2),
        .rd         (id_rd),
        .rs1        (id_rs1),
        .rs2        (id_rs2)
    );

    // Hazard detection; x0 never creates a dependency.
    always_comb begin
        load_use = ex_valid && ex_MemRead && (ex_rd != '0) &&
                   ((id_use_rs1 && (ex_rd == id_rs1)) ||
                    (id_use_rs2 && (ex_rd == id_rs2)));
        bubble     = br_taken_ex || load_use;
        stall_if   = !rst && (stall_ext || (!br_taken_ex && load_use));
        flush_ifid = !rst && !stall_ext && br_taken_ex;
    end

    // Next ID/EX contents: decoded instruction, or an all-zero bubble.
    always_comb begin
        idex_d = '0;
        if (!bubble && inst_valid) begin
            idex_d.valid = 1'b1;
            idex_d.ctrl  = id_ctrl;
            idex_d.rd    = id_rd;
            idex_d.rs1   = id_rs1;
            idex_d.rs2   = id_rs2;
        end
    end

    // ID/EX register; an external stall freezes it, reset clears it regardless.
    always_ff @(posedge clk) begin
        if (rst)             idex_q <= '0;
        else if (!stall_ext) idex_q <= idex_d;
    end

    assign ex_valid    = idex_q.valid;
    assign ex_RegWrite = idex_q.ctrl.reg_write;
    assign ex_MemWrite = idex_q.ctrl.mem_write;
    assign ex_MemRead  = idex_q.ctrl.mem_read;
    assign ex_ALUSrc   = idex_q.ctrl.alu_src;
    assign ex_illegal  = idex_q.ctrl.illegal;
    assign ex_ALUOp    = idex_q.ctrl.alu_op;
    assign ex_EXTOp    = idex_q.ctrl.ext_op;
    assign ex_NPCOp    = idex_q.ctrl.npc_op;
    assign ex_WDSel    = idex_q.ctrl.wd_sel;
    assign ex_DMType   = idex_q.ctrl.dm_type;
    assign ex_rd       = idex_q.rd;
    assign ex_rs1      = idex_q.rs1;
    assign ex_rs2      = idex_q.rs2;

    // EX/MEM and MEM/WB write-back control, frozen together with ID/EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_RegWrite <= 1'b0;
            mem_WDSel    <= '0;
            mem_rd       <= '0;
            wb_RegWrite  <= 1'b0;
            wb_rd        <= '0;
        end else if (!stall_ext) begin
            mem_RegWrite <= ex_valid && ex_RegWrite;
            mem_WDSel    <= ex_WDSel;
            mem_rd       <= ex_rd;
            wb_RegWrite  <= mem_RegWrite;
            wb_rd        <= mem_rd;
        end
    end

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == ex_rs1))   ForwardA = 2'b10;
        else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == ex_rs1)) ForwardA = 2'b01;
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == ex_rs2))   ForwardB = 2'b10;
        else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == ex_rs2)) ForwardB = 2'b01;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance without and one with the M
// extension, driven with hand-encoded RV32 instructions.
module tb_pipe_ctrl;

    localparam logic [4:0] A_ADD  = 5'd1;
    localparam logic [4:0] A_MUL  = 5'd19;
    localparam logic [4:0] A_REMU = 5'd26;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_id;
    logic        inst_valid, br_taken_ex, stall_ext;

    logic       stall_if, flush_ifid, ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_illegal;
    logic [4:0] ex_ALUOp;
    logic [5:0] ex_EXTOp;
    logic [2:0] ex_NPCOp, ex_DMType;
    logic [1:0] ex_WDSel, mem_WDSel, ForwardA, ForwardB;
    logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       mem_RegWrite, wb_RegWrite;

    logic       m_stall_if, m_flush_ifid, m_ex_valid, m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_ALUSrc, m_ex_illegal;
    logic [4:0] m_ex_ALUOp;
    logic [5:0] m_ex_EXTOp;
    logic [2:0] m_ex_NPCOp, m_ex_DMType;
    logic [1:0] m_ex_WDSel, m_mem_WDSel, m_ForwardA, m_ForwardB;
    logic [4:0] m_ex_rd, m_ex_rs1, m_ex_rs2, m_mem_rd, m_wb_rd;
    logic       m_mem_RegWrite, m_wb_RegWrite;

    int tests = 0;
    int fails = 0;

    pipe_ctrl #(.ENABLE_MEXT(0), .RF_AW(5)) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_valid(inst_valid),
        .br_taken_ex(br_taken_ex), .stall_ext(stall_ext),
        .stall_if(stall_if), .flush_ifid(flush_ifid),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_illegal(ex_illegal),
        .ex_ALUOp(ex_ALUOp), .ex_EXTOp(ex_EXTOp), .ex_NPCOp(ex_NPCOp),
        .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_RegWrite(mem_RegWrite), .mem_WDSel(mem_WDSel), .mem_rd(mem_rd),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    pipe_ctrl #(.ENABLE_MEXT(1), .RF_AW(5)) dut_m (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_valid(inst_valid),
        .br_taken_ex(br_taken_ex), .stall_ext(stall_ext),
        .stall_if(m_stall_if), .flush_ifid(m_flush_ifid),
        .ex_valid(m_ex_valid), .ex_RegWrite(m_ex_RegWrite), .ex_MemWrite(m_ex_MemWrite),
        .ex_MemRead(m_ex_MemRead), .ex_ALUSrc(m_ex_ALUSrc), .ex_illegal(m_ex_illegal),
        .ex_ALUOp(m_ex_ALUOp), .ex_EXTOp(m_ex_EXTOp), .ex_NPCOp(m_ex_NPCOp),
        .ex_WDSel(m_ex_WDSel), .ex_DMType(m_ex_DMType),
        .ex_rd(m_ex_rd), .ex_rs1(m_ex_rs1), .ex_rs2(m_ex_rs2),
        .mem_RegWrite(m_mem_RegWrite), .mem_WDSel(m_mem_WDSel), .mem_rd(m_mem_rd),
        .wb_RegWrite(m_wb_RegWrite), .wb_rd(m_wb_rd),
        .ForwardA(m_ForwardA), .ForwardB(m_ForwardB)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] i, input logic v, input logic b, input logic s);
        inst_id = i; inst_valid = v; br_taken_ex = b; stall_ext = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic empty_pipe();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [59:0] all_a, all_b;
        rst = 1'b1;
        drive(32'h002081B3, 1'b1, 1'b1, 1'b1);
        tick();
        all_a = {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_illegal, ex_ALUOp, ex_EXTOp,
                 ex_NPCOp, ex_WDSel, ex_DMType, ex_rd, ex_rs1, ex_rs2, mem_RegWrite, mem_WDSel, mem_rd,
                 wb_RegWrite, wb_rd, stall_if, flush_ifid, ForwardA, ForwardB};
        all_b = {m_ex_valid, m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_ALUSrc, m_ex_illegal, m_ex_ALUOp,
                 m_ex_EXTOp, m_ex_NPCOp, m_ex_WDSel, m_ex_DMType, m_ex_rd, m_ex_rs1, m_ex_rs2, m_mem_RegWrite,
                 m_mem_WDSel, m_mem_rd, m_wb_RegWrite, m_wb_rd, m_stall_if, m_flush_ifid, m_ForwardA, m_ForwardB};
        tests++; if (all_a !== 60'd0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", all_a); end
        tests++; if (all_b !== 60'd0) begin fails++; $display("FAIL reset_outputs_mext: got %h expected 0", all_b); end
        rst = 1'b0;
    endtask

    task automatic test_alu_flow();
        empty_pipe();
        drive(32'h002081B3, 1'b1, 1'b0, 1'b0);
        tick();
        tests++; if ({ex_valid, ex_RegWrite, ex_rd, ex_ALUOp} !== {1'b1, 1'b1, 5'd3, A_ADD}) begin
            fails++; $display("FAIL add_idex: got %b expected %b", {ex_valid, ex_RegWrite, ex_rd, ex_ALUOp}, {1'b1, 1'b1, 5'd3, A_ADD}); end
        tests++; if ({ex_rs1, ex_rs2} !== {5'd1, 5'd2}) begin
            fails++; $display("FAIL add_rs: got %h expected %h", {ex_rs1, ex_rs2}, {5'd1, 5'd2}); end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tests++; if ({mem_RegWrite, mem_rd} !== {1'b1, 5'd3}) begin
            fails++; $display("FAIL add_exmem: got %b expected %b", {mem_RegWrite, mem_rd}, {1'b1, 5'd3}); end
        tick();
        tests++; if ({wb_RegWrite, wb_rd} !== {1'b1, 5'd3}) begin
            fails++; $display("FAIL add_memwb: got %b expected %b", {wb_RegWrite, wb_rd}, {1'b1, 5'd3}); end
    endtask

    task automatic test_decode();
        logic [31:0] insts [14];
        logic [23:0] exps  [14];
        logic [23:0] got, got_m;
        // {RegWrite,MemWrite,MemRead,ALUSrc,illegal} ALUOp EXTOp NPCOp WDSel DMType
        insts[0]  = 32'h002081B3; exps[0]  = {5'b10000, 5'd1,  6'b000000, 3'b000, 2'b00, 3'b000}; // add
        insts[1]  = 32'h0000A283; exps[1]  = {5'b10110, 5'd1,  6'b010000, 3'b000, 2'b01, 3'b010}; // lw
        insts[2]  = 32'h0020A223; exps[2]  = {5'b01010, 5'd1,  6'b001000, 3'b000, 2'b00, 3'b010}; // sw
        insts[3]  = 32'h00208063; exps[3]  = {5'b00000, 5'd13, 6'b000100, 3'b001, 2'b00, 3'b000}; // beq
        insts[4]  = 32'h000000EF; exps[4]  = {5'b10000, 5'd1,  6'b000001, 3'b010, 2'b10, 3'b000}; // jal
        insts[5]  = 32'h000100E7; exps[5]  = {5'b10010, 5'd1,  6'b010000, 3'b100, 2'b10, 3'b000}; // jalr
        insts[6]  = 32'h000010B7; exps[6]  = {5'b10010, 5'd11, 6'b000010, 3'b000, 2'b00, 3'b000}; // lui
        insts[7]  = 32'h00000097; exps[7]  = {5'b10010, 5'd12, 6'b000010, 3'b000, 2'b00, 3'b000}; // auipc
        insts[8]  = 32'h4010D093; exps[8]  = {5'b10010, 5'd8,  6'b100000, 3'b000, 2'b00, 3'b000}; // srai
        insts[9]  = 32'h0010D093; exps[9]  = {5'b10010, 5'd7,  6'b100000, 3'b000, 2'b00, 3'b000}; // srli
        insts[10] = 32'h402081B3; exps[10] = {5'b10000, 5'd2,  6'b000000, 3'b000, 2'b00, 3'b000}; // sub
        insts[11] = 32'h4020D1B3; exps[11] = {5'b10000, 5'd8,  6'b000000, 3'b000, 2'b00, 3'b000}; // sra
        insts[12] = 32'h0020E063; exps[12] = {5'b00000, 5'd17, 6'b000100, 3'b001, 2'b00, 3'b000}; // bltu
        insts[13] = 32'h00014083; exps[13] = {5'b10110, 5'd1,  6'b010000, 3'b000, 2'b01, 3'b100}; // lbu
        empty_pipe();
        for (int k = 0; k < 14; k++) begin
            drive(insts[k], 1'b1, 1'b0, 1'b0);
            tick();
            got   = {ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_illegal,
                     ex_ALUOp, ex_EXTOp, ex_NPCOp, ex_WDSel, ex_DMType};
            got_m = {m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_ALUSrc, m_ex_illegal,
                     m_ex_ALUOp, m_ex_EXTOp, m_ex_NPCOp, m_ex_WDSel, m_ex_DMType};
            tests++; if (got !== exps[k] || ex_valid !== 1'b1) begin
                fails++; $display("FAIL decode[%0d] %h: got %b valid %b expected %b", k, insts[k], got, ex_valid, exps[k]); end
            tests++; if (got_m !== exps[k]) begin
                fails++; $display("FAIL decode_mext[%0d] %h: got %b expected %b", k, insts[k], got_m, exps[k]); end
        end
    endtask

    task automatic test_mext_illegal();
        empty_pipe();
        drive(32'h023100B3, 1'b1, 1'b0, 1'b0); // mul x1,x2,x3
        tick();
        tests++; if ({ex_valid, ex_illegal, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_NPCOp} !== 8'b1100_0000) begin
            fails++; $display("FAIL mul_no_mext: got %b expected 11000000",
                              {ex_valid, ex_illegal, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_NPCOp}); end
        tests++; if ({m_ex_illegal, m_ex_RegWrite, m_ex_ALUOp} !== {1'b0, 1'b1, A_MUL}) begin
            fails++; $display("FAIL mul_mext: got %b expected %b", {m_ex_illegal, m_ex_RegWrite, m_ex_ALUOp}, {1'b0, 1'b1, A_MUL}); end
        drive(32'h023170B3, 1'b1, 1'b0, 1'b0); // remu x1,x2,x3
        tick();
        tests++; if ({m_ex_illegal, m_ex_RegWrite, m_ex_ALUOp} !== {1'b0, 1'b1, A_REMU}) begin
            fails++; $display("FAIL remu_mext: got %b expected %b", {m_ex_illegal, m_ex_RegWrite, m_ex_ALUOp}, {1'b0, 1'b1, A_REMU}); end
        tests++; if ({ex_illegal, ex_RegWrite} !== 2'b10) begin
            fails++; $display("FAIL remu_no_mext: got %b expected 10", {ex_illegal, ex_RegWrite}); end
        drive(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        tick();
        tests++; if ({ex_valid, ex_illegal, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_NPCOp,
                      m_ex_illegal, m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_NPCOp} !== 15'b1100_0000_1000_000) begin
            fails++; $display("FAIL illegal_opcode: got %b expected 110000001000000",
                              {ex_valid, ex_illegal, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_NPCOp,
                               m_ex_illegal, m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_NPCOp}); end
    endtask

    task automatic test_load_use();
        empty_pipe();
        drive(32'h0000A283, 1'b1, 1'b0, 1'b0); // lw x5,0(x1)
        tick();
        drive(32'h00228333, 1'b1, 1'b0, 1'b0); // add x6,x5,x2
        tests++; if ({stall_if, flush_ifid} !== 2'b10) begin
            fails++; $display("FAIL load_use_stall: got %b expected 10", {stall_if, flush_ifid}); end
        tick();
        tests++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_rd} !== 8'd0 || stall_if !== 1'b0) begin
            fails++; $display("FAIL load_use_bubble: got %b stall %b expected 0/0",
                              {ex_valid, ex_RegWrite, ex_MemRead, ex_rd}, stall_if); end
        tick();
        tests++; if ({ex_valid, ex_rd, ForwardA, ForwardB} !== {1'b1, 5'd6, 2'b01, 2'b00}) begin
            fails++; $display("FAIL load_use_fwd: got %b expected %b", {ex_valid, ex_rd, ForwardA, ForwardB}, {1'b1, 5'd6, 2'b01, 2'b00}); end
        empty_pipe();
        drive(32'h0000A003, 1'b1, 1'b0, 1'b0); // lw x0,0(x1)
        tick();
        drive(32'h00200333, 1'b1, 1'b0, 1'b0); // add x6,x0,x2
        tests++; if (stall_if !== 1'b0) begin
            fails++; $display("FAIL load_use_x0: got %b expected 0", stall_if); end
    endtask

    task automatic test_forward();
        empty_pipe();
        drive(32'h00100093, 1'b1, 1'b0, 1'b0); tick(); // addi x1,x0,1
        drive(32'h00108113, 1'b1, 1'b0, 1'b0); tick(); // addi x2,x1,1
        tests++; if (ForwardA !== 2'b10) begin
            fails++; $display("FAIL fwd_exmem_a: got %b expected 10", ForwardA); end
        drive(32'h001101B3, 1'b1, 1'b0, 1'b0); tick(); // add x3,x2,x1
        tests++; if ({ForwardA, ForwardB} !== 4'b1001) begin
            fails++; $display("FAIL fwd_a_b: got %b expected 1001", {ForwardA, ForwardB}); end
        empty_pipe();
        drive(32'h00100093, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h00100093, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h00108113, 1'b1, 1'b0, 1'b0); tick();
        tests++; if (ForwardA !== 2'b10) begin
            fails++; $display("FAIL fwd_priority: got %b expected 10", ForwardA); end
        empty_pipe();
        drive(32'h00100013, 1'b1, 1'b0, 1'b0); tick(); // addi x0,x0,1
        drive(32'h00000113, 1'b1, 1'b0, 1'b0); tick(); // addi x2,x0,0
        tests++; if (ForwardA !== 2'b00) begin
            fails++; $display("FAIL fwd_x0: got %b expected 00", ForwardA); end
    endtask

    task automatic test_branch_flush();
        empty_pipe();
        drive(32'h0000A283, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h00228333, 1'b1, 1'b1, 1'b0); // load-use and taken branch together
        tests++; if ({flush_ifid, stall_if} !== 2'b10) begin
            fails++; $display("FAIL branch_flush: got %b expected 10", {flush_ifid, stall_if}); end
        tick();
        tests++; if ({ex_valid, ex_RegWrite, ex_rd} !== 7'd0) begin
            fails++; $display("FAIL branch_bubble: got %b expected 0", {ex_valid, ex_RegWrite, ex_rd}); end
        drive(32'h00100093, 1'b1, 1'b1, 1'b0); tick();
        tests++; if (ex_valid !== 1'b0) begin
            fails++; $display("FAIL branch_bubble_addi: got %b expected 0", ex_valid); end
    endtask

    task automatic test_stall_ext();
        empty_pipe();
        drive(32'h002081B3, 1'b1, 1'b0, 1'b0); tick(); // add x3
        drive(32'h0000A283, 1'b1, 1'b0, 1'b0); tick(); // lw x5
        drive(32'h402081B3, 1'b1, 1'b1, 1'b1);
        tests++; if ({stall_if, flush_ifid} !== 2'b10) begin
            fails++; $display("FAIL stall_ext_outputs: got %b expected 10", {stall_if, flush_ifid}); end
        tick();
        tests++; if ({ex_valid, ex_MemRead, ex_rd, mem_RegWrite, mem_rd, wb_RegWrite} !== {1'b1, 1'b1, 5'd5, 1'b1, 5'd3, 1'b0}) begin
            fails++; $display("FAIL stall_ext_hold: got %b expected %b",
                              {ex_valid, ex_MemRead, ex_rd, mem_RegWrite, mem_rd, wb_RegWrite}, {1'b1, 1'b1, 5'd5, 1'b1, 5'd3, 1'b0}); end
        drive(32'h00228333, 1'b1, 1'b0, 1'b1); tick(); // load-use under freeze: no bubble
        tests++; if ({stall_if, ex_valid, ex_rd} !== {1'b1, 1'b1, 5'd5}) begin
            fails++; $display("FAIL stall_ext_no_bubble: got %b expected %b", {stall_if, ex_valid, ex_rd}, {1'b1, 1'b1, 5'd5}); end
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick();
        tests++; if ({ex_valid, mem_RegWrite, mem_rd, wb_RegWrite, wb_rd} !== {1'b0, 1'b1, 5'd5, 1'b1, 5'd3}) begin
            fails++; $display("FAIL stall_ext_release: got %b expected %b",
                              {ex_valid, mem_RegWrite, mem_rd, wb_RegWrite, wb_rd}, {1'b0, 1'b1, 5'd5, 1'b1, 5'd3}); end
    endtask

    task automatic test_reset_in_stall();
        logic [59:0] all_a;
        empty_pipe();
        drive(32'h002081B3, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h0000A283, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h00100093, 1'b1, 1'b0, 1'b0); tick();
        rst = 1'b1;
        drive(32'h00228333, 1'b1, 1'b0, 1'b1);
        tick();
        all_a = {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_illegal, ex_ALUOp, ex_EXTOp,
                 ex_NPCOp, ex_WDSel, ex_DMType, ex_rd, ex_rs1, ex_rs2, mem_RegWrite, mem_WDSel, mem_rd,
                 wb_RegWrite, wb_rd, stall_if, flush_ifid, ForwardA, ForwardB};
        tests++; if (all_a !== 60'd0) begin
            fails++; $display("FAIL reset_in_stall: got %h expected 0", all_a); end
        rst = 1'b0;
        drive(32'h002081B3, 1'b1, 1'b0, 1'b0); tick();
        tests++; if ({ex_valid, ex_rd} !== {1'b1, 5'd3}) begin
            fails++; $display("FAIL after_reset_advance: got %b expected %b", {ex_valid, ex_rd}, {1'b1, 5'd3}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_alu_flow();
        test_decode();
        test_mext_illegal();
        test_load_use();
        test_forward();
        test_branch_flush();
        test_stall_ext();
        test_reset_in_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ENABLE_MEXT, default 0, meaning: 1 adds RV32M decode.
REQ-002 Parameter RF_AW, default 5, meaning: register-address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 inst_id  in  32  instruction held in IF/ID.
REQ-007 inst_valid  in  1  inst_id is a real instruction.
REQ-008 br_taken_ex  in  1  branch/jump in EX resolved taken, so redirect.
REQ-009 stall_ext  in  1  memory busy; freeze whole pipeline.
REQ-010 stall_if  out  1  hold PC and IF/ID.
REQ-011 flush_ifid  out  1  invalidate IF/ID.
REQ-012 ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_illegal  out  1 each  ID/EX control.
REQ-013 ex_ALUOp 5, ex_EXTOp 6, ex_NPCOp 3, ex_WDSel 2, ex_DMType 3  out  ID/EX encoded control.
REQ-014 ex_rd, ex_rs1, ex_rs2  out  RF_AW each  ID/EX register indices.
REQ-015 mem_RegWrite 1, mem_WDSel 2, mem_rd RF_AW  out  EX/MEM control.
REQ-016 wb_RegWrite 1, wb_rd RF_AW  out  MEM/WB control.
REQ-017 ForwardA, ForwardB  out  2  operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB.

Function
REQ-018 Decode SHALL be combinational from inst_id, registered into ID/EX on the next clk edge (1-cycle latency).
REQ-019 Encodings SHALL be: EXTOp one-hot (ITYPE_SHAMT=100000, ITYPE=010000, STYPE=001000, BTYPE=000100, UTYPE=000010, JTYPE=000001); WDSel 00 ALU, 01 MEM, 10 PC; NPCOp 000 +4, 001 branch, 010 jal, 100 jalr.
REQ-020 NPCOp SHALL NOT depend on any flag; branch outcome is resolved in EX and returned on br_taken_ex.
REQ-021 RegWrite SHALL be 1 for R, I-ALU, load, jal, jalr, lui, auipc; MemRead SHALL be 1 for loads only; MemWrite SHALL be 1 for stores only.
REQ-022 DMType SHALL be funct3 for loads and stores, 000 otherwise.
REQ-023 Every ALUOp value SHALL be unique (0 = NOP); srli/srai and srl/sra SHALL be distinguished by funct7[5].
REQ-024 With ENABLE_MEXT=1, opcode 0110011 with funct7 0000001 SHALL map funct3 to the eight M ALUOp codes; with 0 it SHALL be illegal.
REQ-025 An unmatched opcode/funct combination with inst_valid=1 SHALL set ex_illegal=1 with RegWrite, MemWrite, MemRead and NPCOp zero.
REQ-026 Load-use: ex_valid&ex_MemRead&ex_rd!=0&(ex_rd==rs1 or ex_rd==rs2 of a source-using ID instruction) SHALL give stall_if=1 and insert a bubble (valid=0, all control 0) into ID/EX for exactly one cycle.
REQ-027 br_taken_ex=1 SHALL give flush_ifid=1 and a bubble into ID/EX next edge; stall_if SHALL be 0.
REQ-028 stall_ext=1 SHALL hold every pipeline register, give stall_if=1, flush_ifid=0, no bubble.
REQ-029 Priority SHALL be rst > stall_ext > br_taken_ex > load-use.
REQ-030 ForwardA/B SHALL be 10 when mem_RegWrite&mem_rd!=0&mem_rd==ex_rs1/rs2, else 01 on the equivalent wb match, else 00; EX/MEM SHALL win.
REQ-031 Register index 0 SHALL never forward or stall.

Reset
REQ-032 On rst, every valid bit and every output SHALL be 0 at the next edge, including during stall_ext.
REQ-033 Pipeline registers SHALL advance normally on the first edge after rst deasserts.

Structure
REQ-034 pipe_ctrl_pkg SHALL hold the ALUOp, EXTOp, NPCOp and WDSel constants and the opcode constants.
REQ-035 Decode SHALL be a sub-module pipe_ctrl_dec (combinational); hazard, forwarding and pipeline registers SHALL live in pipe_ctrl.

Verification
REQ-036 add x3,x1,x2 (0x002081B3) -> next cycle ex_RegWrite=1, ex_rd=3, ex_ALUOp=ADD; two cycles later wb_RegWrite=1, wb_rd=3.
REQ-037 lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333) -> one cycle with stall_if=1 and a bubble, then ForwardA=01 with add in EX.
REQ-038 addi x1,x0,1 (0x00100093) then addi x2,x1,1 (0x00108113) -> ForwardA=10; rd=x0 variant gives ForwardA=00.
REQ-039 Load-use and br_taken_ex together -> flush_ifid=1, stall_if=0, ID/EX bubble.
REQ-040 mul x1,x2,x3 (0x023100B3) -> ENABLE_MEXT=0: ex_illegal=1, ex_RegWrite=0; ENABLE_MEXT=1: ex_ALUOp=MUL, ex_RegWrite=1.
REQ-041 rst during stall_ext=1 with a full pipeline -> all valids and outputs 0 next edge.
